// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUOp/FuncCode
// encodings, arbiter state type, default data width and small helpers.
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  // Width of the settle counter; holds SETTLE-1 for SETTLE in 1..15.
  localparam int CNT_W = 4;

  // ALUOp encodings.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;  // load/store address add
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;  // branch compare subtract
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;  // operation chosen by FuncCode

  // FuncCode encodings used with ALU_OP_RTYPE.
  localparam logic [3:0] FUNC_AND = 4'b0000;
  localparam logic [3:0] FUNC_OR  = 4'b0001;
  localparam logic [3:0] FUNC_ADD = 4'b0010;
  localparam logic [3:0] FUNC_SUB = 4'b0110;
  localparam logic [3:0] FUNC_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester selected by ptr. Purely combinational.
module alu_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Pick at most one requester from the request vector and priority pointer.
  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. Requests are granted
// round-robin in IDLE, the ALU inputs are held for SETTLE cycles, and the
// registered result is returned on a tagged valid/ready response channel.
// Optional statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req0_op,
  input  logic [3:0]        req0_func,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req1_op,
  input  logic [3:0]        req1_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [1:0]        alu_op,
  output logic [3:0]        alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       stall_cnt,
`endif
  output logic              busy
);

  // A zero settle time would capture before the ALU ever saw its inputs.
  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_arbiter: SETTLE must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

  arb_state_t       state;
  logic             rr_ptr;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       arb_req;
  logic [1:0]       grant;
  logic             grant_idx;
  logic             accept;

  // Only IDLE offers ready, so an in-flight op can never be overtaken.
  assign arb_req = (state == IDLE) ? req_valid : 2'b00;

  alu_rr_arbiter2 u_rr (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = grant;
  assign grant_idx = grant[1];
  assign accept    = |grant;

  // Request/issue/response sequencing with all ALU and response outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      cnt       <= '0;
      alu_op    <= '0;
      alu_func  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op   <= grant_idx ? req1_op   : req0_op;
            alu_func <= grant_idx ? req1_func : req0_func;
            alu_a    <= grant_idx ? req1_a    : req0_a;
            alu_b    <= grant_idx ? req1_b    : req0_b;
            owner    <= grant_idx;
            rr_ptr   <= ~grant_idx;
            cnt      <= CNT_INIT;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt == '0) begin
            rsp_data  <= alu_result;
            rsp_zero  <= alu_zero;
            rsp_id    <= owner;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Saturating per-requester grant counts and response back-pressure cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (grant[0]) grant_cnt0 <= sat_inc16(grant_cnt0);
      if (grant[1]) grant_cnt1 <= sat_inc16(grant_cnt1);
      if (state == RESP && !rsp_ready) stall_cnt <= sat_inc16(stall_cnt);
    end
  end
`endif

endmodule
